// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman word loader and its character classifier.
package hangman_pkg;

    localparam int unsigned DEFAULT_WORD_LEN = 5;
    localparam int unsigned DEFAULT_CHAR_W   = 8;

    localparam logic [7:0] ASCII_BS   = 8'h08;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_Z    = 8'h5A;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam logic [7:0] ASCII_CASE = 8'h20;

    typedef enum logic [2:0] {
        StEmpty,
        StCollect,
        StWaitRdy,
        StArm,
        StLocked
    } loader_state_e;

endpackage

// File: rtl/hangman_char_classify.sv
// Byte classifier: letter / backspace / enter, with the normalized uppercase letter.
// HANGMAN_LOADER_LOWERCASE_EN folds 'a'..'z' to uppercase letters.
module hangman_char_classify
    import hangman_pkg::*;
#(
    parameter int unsigned CHAR_W = DEFAULT_CHAR_W
) (
    input  logic [CHAR_W-1:0] data_i,
    output logic              is_letter_o,
    output logic              is_bs_o,
    output logic              is_enter_o,
    output logic [CHAR_W-1:0] letter_o
);

    always_comb begin
        is_bs_o     = (data_i == CHAR_W'(ASCII_BS));
        is_enter_o  = (data_i == CHAR_W'(ASCII_CR));
        is_letter_o = (data_i >= CHAR_W'(ASCII_A)) && (data_i <= CHAR_W'(ASCII_Z));
        letter_o    = data_i;
`ifdef HANGMAN_LOADER_LOWERCASE_EN
        if ((data_i >= CHAR_W'(ASCII_LC_A)) && (data_i <= CHAR_W'(ASCII_LC_Z))) begin
            is_letter_o = 1'b1;
            letter_o    = data_i - CHAR_W'(ASCII_CASE);
        end
`endif
    end

endmodule

// File: rtl/hangman_word_loader.sv
// Assembles host characters into the secret word and issues the game start pulse.
// Optional lowercase folding is enabled by HANGMAN_LOADER_LOWERCASE_EN (see classifier).
module hangman_word_loader
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN = DEFAULT_WORD_LEN,
    parameter int unsigned CHAR_W   = DEFAULT_CHAR_W
) (
    input  logic                       tb_clk,
    input  logic                       nRst,
    input  logic [CHAR_W-1:0]          rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    input  logic                       game_rdy,
    input  logic                       clear,
    output logic [WORD_LEN*CHAR_W-1:0] set_word,
    output logic                       word_valid,
    output logic                       toggle_state,
    output logic [2:0]                 letter_count,
    output logic                       err_char
);

    localparam int         WL      = int'(WORD_LEN);
    localparam int         CW      = int'(CHAR_W);
    localparam logic [2:0] FullCnt = 3'(WORD_LEN);

    loader_state_e             state_q;
    logic [WORD_LEN*CHAR_W-1:0] word_q;
    logic [2:0]                count_q;
    logic                      err_q;
    logic                      toggle_q;
    logic                      valid_q;

    logic              is_letter;
    logic              is_bs;
    logic              is_enter;
    logic [CHAR_W-1:0] letter;
    logic              accept;

    hangman_char_classify #(
        .CHAR_W (CHAR_W)
    ) u_classify (
        .data_i      (rx_data),
        .is_letter_o (is_letter),
        .is_bs_o     (is_bs),
        .is_enter_o  (is_enter),
        .letter_o    (letter)
    );

    assign rx_ready = ((state_q == StEmpty) || (state_q == StCollect)) && !clear;
    assign accept   = rx_valid && rx_ready;

    always_ff @(posedge tb_clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= StEmpty;
            word_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            toggle_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            err_q    <= 1'b0;
            toggle_q <= 1'b0;
            if (clear) begin
                state_q <= StEmpty;
                word_q  <= '0;
                count_q <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    StEmpty, StCollect: begin
                        if (accept) begin
                            if (is_letter) begin
                                if (count_q < FullCnt) begin
                                    // Slot k sits at byte k counted from the MSB end.
                                    for (int i = 0; i < WL; i++) begin
                                        if (count_q == 3'(i)) begin
                                            word_q[(WL-1-i)*CW +: CW] <= letter;
                                        end
                                    end
                                    count_q <= count_q + 3'd1;
                                    state_q <= StCollect;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end else if (is_bs) begin
                                if (count_q != 3'd0) begin
                                    for (int i = 0; i < WL; i++) begin
                                        if (count_q == 3'(i + 1)) begin
                                            word_q[(WL-1-i)*CW +: CW] <= '0;
                                        end
                                    end
                                    count_q <= count_q - 3'd1;
                                    if (count_q == 3'd1) begin
                                        state_q <= StEmpty;
                                    end
                                end
                            end else if (is_enter) begin
                                if (count_q == FullCnt) begin
                                    state_q <= StWaitRdy;
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StWaitRdy: begin
                        if (game_rdy) begin
                            state_q  <= StArm;
                            toggle_q <= 1'b1;
                            valid_q  <= 1'b1;
                        end
                    end
                    StArm: begin
                        state_q <= StLocked;
                    end
                    StLocked: begin
                        state_q <= StLocked;
                    end
                    default: begin
                        state_q <= StEmpty;
                    end
                endcase
            end
        end
    end

    assign set_word     = word_q;
    assign letter_count = count_q;
    assign err_char     = err_q;
    assign toggle_state = toggle_q;
    assign word_valid   = valid_q;

endmodule

// File: tb/tb_hangman_word_loader.sv
// Scoreboard bench for hangman_word_loader: directed plan cases plus randomized byte streams.
module tb_hangman_word_loader;

    localparam int WL = 5;

    logic        tb_clk;
    logic        nRst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        game_rdy;
    logic        clear;
    logic [39:0] set_word;
    logic        word_valid;
    logic        toggle_state;
    logic [2:0]  letter_count;
    logic        err_char;

    hangman_word_loader #(
        .WORD_LEN (5),
        .CHAR_W   (8)
    ) dut (
        .tb_clk       (tb_clk),
        .nRst         (nRst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .game_rdy     (game_rdy),
        .clear        (clear),
        .set_word     (set_word),
        .word_valid   (word_valid),
        .toggle_state (toggle_state),
        .letter_count (letter_count),
        .err_char     (err_char)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_tog;
        logic [39:0] word;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] m_word[$];
    bit         m_wait;
    bit         m_locked;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] m_pack();
        logic [39:0] w;
        w = '0;
        for (int i = 0; i < WL; i++) begin
            w = {w[31:0], (i < m_word.size()) ? m_word[i] : 8'h00};
        end
        return w;
    endfunction

    function automatic void m_reset();
        m_word.delete();
        m_wait   = 1'b0;
        m_locked = 1'b0;
    endfunction

    function automatic void push_ev(input bit is_tog, input logic [39:0] w);
        ev_t e;
        e.is_tog = is_tog;
        e.word   = w;
        exp_q.push_back(e);
    endfunction

    // Reference behaviour for one accepted byte.
    function automatic void m_accept(input logic [7:0] b);
        logic [7:0] l;
        bit         letter;
        l      = b;
        letter = (b >= 8'h41) && (b <= 8'h5A);
`ifdef HANGMAN_LOADER_LOWERCASE_EN
        if ((b >= 8'h61) && (b <= 8'h7A)) begin
            letter = 1'b1;
            l      = b - 8'h20;
        end
`endif
        if (letter) begin
            if (m_word.size() < WL) m_word.push_back(l);
            else push_ev(1'b0, '0);
        end else if (b == 8'h08) begin
            if (m_word.size() > 0) void'(m_word.pop_back());
        end else if (b == 8'h0D) begin
            if (m_word.size() == WL) begin
                m_wait = 1'b1;
                push_ev(1'b1, m_pack());
            end else begin
                push_ev(1'b0, '0);
            end
        end else begin
            push_ev(1'b0, '0);
        end
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 8'h41 + 8'($urandom_range(0, 25));
            5:             return 8'h61 + 8'($urandom_range(0, 25));
            6, 9:          return 8'h08;
            7:             return 8'h0D;
            default:       return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge tb_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        chk("rx_ready", rx_ready, !m_wait && !m_locked && !clear);
        if (!m_wait && !m_locked) m_accept(b);
        @(posedge tb_clk);
        #1;
        rx_valid = 1'b0;
        chk("letter_count", letter_count, m_word.size());
        chk("set_word", set_word, m_pack());
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Holds game_rdy low for d cycles in WAIT_RDY, then expects a single start pulse.
    task automatic lock_word(input int d);
        game_rdy = 1'b0;
        for (int i = 0; i < d; i++) begin
            @(negedge tb_clk);
            chk("rx_ready_wait", rx_ready, 0);
            chk("toggle_wait", toggle_state, 0);
            chk("word_valid_wait", word_valid, 0);
        end
        @(negedge tb_clk);
        game_rdy = 1'b1;
        @(negedge tb_clk);
        #1;
        chk("toggle_pulse", toggle_state, 1);
        chk("word_valid_arm", word_valid, 1);
        @(negedge tb_clk);
        #1;
        chk("toggle_end", toggle_state, 0);
        chk("word_valid_locked", word_valid, 1);
        m_wait   = 1'b0;
        m_locked = 1'b1;
        game_rdy = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge tb_clk);
        clear    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        #1;
        chk("rx_ready_clear", rx_ready, 0);
        @(posedge tb_clk);
        #1;
        clear    = 1'b0;
        rx_valid = 1'b0;
        m_reset();
        chk("clear_word", set_word, 0);
        chk("clear_count", letter_count, 0);
        chk("clear_valid", word_valid, 0);
    endtask

    // Monitor: every err_char / toggle_state pulse must match the next expected event.
    always @(negedge tb_clk) begin
        ev_t e;
        if (nRst && (err_char || toggle_state)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: err_char=%0b toggle_state=%0b, expected none at %0t",
                         err_char, toggle_state, $time);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", toggle_state, e.is_tog);
                if (e.is_tog) chk("word_at_start", set_word, e.word);
            end
        end
    end

    initial begin
        nRst     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        game_rdy = 1'b0;
        clear    = 1'b0;
        m_reset();
        repeat (3) @(posedge tb_clk);
        #1;
        chk("rst_word", set_word, 0);
        chk("rst_count", letter_count, 0);
        chk("rst_flags", {word_valid, toggle_state, err_char}, 0);
        @(negedge tb_clk);
        rx_valid = 1'b0;
        nRst     = 1'b1;
        #1;
        chk("rst_ready", rx_ready, 1);

        // APPLE with game_rdy already high: pulse on the second edge after Enter.
        game_rdy = 1'b1;
        send_str("APPLE");
        send_byte(8'h0D);
        @(negedge tb_clk);
        #1;
        chk("apple_no_early_pulse", toggle_state, 0);
        @(negedge tb_clk);
        #1;
        chk("apple_pulse", toggle_state, 1);
        chk("apple_word", set_word, 40'h4150504C45);
        @(negedge tb_clk);
        #1;
        chk("apple_pulse_end", toggle_state, 0);
        chk("apple_valid", word_valid, 1);
        m_wait   = 1'b0;
        m_locked = 1'b1;
        game_rdy = 1'b0;
        do_clear();

        send_str("APX");
        send_byte(8'h08);
        send_str("PLE");
        chk("bs_word", set_word, 40'h4150504C45);
        send_byte(8'h0D);
        lock_word(20);
        do_clear();
        send_byte(8'h08);
        chk("bs_empty_count", letter_count, 0);

        send_str("MOORE");
        send_byte(8'h5A);
        send_byte(8'h33);
        chk("moore_word", set_word, 40'h4D4F4F5245);
        do_clear();
        send_str("MOO");
        send_byte(8'h0D);
        chk("short_enter_count", letter_count, 3);
        do_clear();

        send_str("moore");
`ifdef HANGMAN_LOADER_LOWERCASE_EN
        chk("lower_word", set_word, 40'h4D4F4F5245);
`else
        chk("lower_count", letter_count, 0);
`endif
        send_byte(8'h0D);
        if (m_wait) lock_word(1);
        do_clear();

        // Reset while in ARM discards everything immediately.
        send_str("CRANE");
        send_byte(8'h0D);
        @(negedge tb_clk);
        game_rdy = 1'b1;
        @(negedge tb_clk);
        #1;
        chk("arm_pulse", toggle_state, 1);
        nRst = 1'b0;
        #1;
        chk("arm_rst_flags", {word_valid, toggle_state, err_char}, 0);
        chk("arm_rst_word", set_word, 0);
        chk("arm_rst_count", letter_count, 0);
        @(negedge tb_clk);
        nRst     = 1'b1;
        game_rdy = 1'b0;
        m_reset();

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(3, 14);
            for (int k = 0; k < n; k++) begin
                if (m_wait) break;
                send_byte(rand_byte());
                if ($urandom_range(0, 19) == 0) do_clear();
            end
            if (!m_wait) begin
                while (m_word.size() < WL) send_byte(8'h41 + 8'($urandom_range(0, 25)));
                send_byte(8'h0D);
            end
            lock_word($urandom_range(0, 4));
            send_byte(rand_byte());
            do_clear();
        end

        repeat (3) @(negedge tb_clk);
        chk("events_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
